// File: rtl/jt12_wrsched_if.sv
// Bus bundle between the two write requesters, the JT12 chip port and the write scheduler.
// The scheduler connects through the slave modport; the requester/chip side uses master.
interface jt12_wrsched_if #(
   parameter int DEPTH_LOG2 = 2
);
   logic                  a_req;
   logic                  a_part;
   logic [7:0]            a_reg;
   logic [7:0]            a_val;
   logic                  a_ack;
   logic                  b_req;
   logic                  b_part;
   logic [7:0]            b_reg;
   logic [7:0]            b_val;
   logic                  b_ack;
   logic [7:0]            chip_dout;
   logic                  cs_n;
   logic                  wr_n;
   logic [1:0]            addr;
   logic [7:0]            din;
   logic [DEPTH_LOG2:0]   pending;
   logic                  idle;
   logic                  timeout_err;

   modport master (
      output a_req, a_part, a_reg, a_val, b_req, b_part, b_reg, b_val, chip_dout,
      input  a_ack, b_ack, cs_n, wr_n, addr, din, pending, idle, timeout_err
   );

   modport slave (
      input  a_req, a_part, a_reg, a_val, b_req, b_part, b_reg, b_val, chip_dout,
      output a_ack, b_ack, cs_n, wr_n, addr, din, pending, idle, timeout_err
   );
endinterface

// File: rtl/jt12_wrsched.sv
// JT12 write scheduler: round-robin arbitration of two requesters into a FIFO, then
// address/data strobes to the chip, each followed by a hold and a busy poll.
module jt12_wrsched #(
   parameter int DEPTH_LOG2 = 2,
   parameter int HOLD       = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clk_en,
   jt12_wrsched_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2 + 1)'(32'd0);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(32'd1);
   localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(32'd1);
   localparam logic [3:0]            HOLD_LAST = 4'(HOLD - 1);
   localparam logic [7:0]            POLL_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_A   = 3'd1,
      HOLD_A = 3'd2,
      POLL_A = 3'd3,
      WR_D   = 3'd4,
      HOLD_D = 3'd5,
      POLL_D = 3'd6
   } state_t;

   state_t                state_r;
   logic [16:0]           mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   cnt_r;
   logic                  pref_b_r;
   logic                  a_ack_r;
   logic                  b_ack_r;
   logic [8:0]            work_r;
   logic [3:0]            hold_cnt_r;
   logic [7:0]            poll_cnt_r;
   logic                  cs_n_r;
   logic                  wr_n_r;
   logic [1:0]            addr_r;
   logic [7:0]            din_r;
   logic                  idle_r;
   logic                  timeout_err_r;

   logic                  elig_a_s;
   logic                  elig_b_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  grant_a_s;
   logic                  grant_b_s;
   logic                  push_s;
   logic [16:0]           push_data_s;
   logic [16:0]           head_s;
   logic                  busy_s;
   logic                  poll_done_s;
   logic                  pop_s;
   logic [DEPTH_LOG2:0]   cnt_nxt_s;
   logic                  unused_status_s;

   // Arbitration, FIFO push/pop decisions and next occupancy.
   always_comb begin
      elig_a_s        = bus.a_req & ~a_ack_r;
      elig_b_s        = bus.b_req & ~b_ack_r;
      full_s          = (cnt_r == CNT_FULL);
      empty_s         = (cnt_r == CNT_ZERO);
      grant_a_s       = 1'b0;
      grant_b_s       = 1'b0;
      if (full_s) begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end else if (elig_a_s && elig_b_s) begin
         grant_a_s = ~pref_b_r;
         grant_b_s = pref_b_r;
      end else begin
         grant_a_s = elig_a_s;
         grant_b_s = elig_b_s;
      end
      push_s          = grant_a_s | grant_b_s;
      push_data_s     = grant_b_s ? {bus.b_part, bus.b_reg, bus.b_val}
                                  : {bus.a_part, bus.a_reg, bus.a_val};
      head_s          = mem_r[rd_ptr_r];
      busy_s          = bus.chip_dout[7];
      unused_status_s = ^bus.chip_dout[6:0];
      // A poll ends when busy is clear or the poll budget is exhausted.
      poll_done_s     = ~busy_s | (poll_cnt_r == POLL_LAST);
      pop_s           = ~empty_s & ((state_r == IDLE) | ((state_r == POLL_D) & poll_done_s));
      if (push_s && !pop_s) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
         cnt_nxt_s = cnt_r - CNT_ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // FIFO, arbiter state, transfer FSM and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= 17'd0;
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         cnt_r         <= CNT_ZERO;
         pref_b_r      <= 1'b0;
         a_ack_r       <= 1'b0;
         b_ack_r       <= 1'b0;
         work_r        <= 9'd0;
         hold_cnt_r    <= 4'd0;
         poll_cnt_r    <= 8'd0;
         cs_n_r        <= 1'b1;
         wr_n_r        <= 1'b1;
         addr_r        <= 2'd0;
         din_r         <= 8'd0;
         idle_r        <= 1'b1;
         timeout_err_r <= 1'b0;
      end else if (clk_en) begin
         a_ack_r    <= grant_a_s;
         b_ack_r    <= grant_b_s;
         cnt_r      <= cnt_nxt_s;
         idle_r     <= 1'b0;
         hold_cnt_r <= 4'd0;
         poll_cnt_r <= 8'd0;
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            pref_b_r        <= grant_a_s;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            work_r   <= {head_s[16], head_s[7:0]};
         end
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  state_r <= WR_A;
                  cs_n_r  <= 1'b0;
                  wr_n_r  <= 1'b0;
                  addr_r  <= {head_s[16], 1'b0};
                  din_r   <= head_s[15:8];
               end else begin
                  idle_r  <= (cnt_nxt_s == CNT_ZERO);
               end
            end
            WR_A: begin
               state_r <= HOLD_A;
               cs_n_r  <= 1'b1;
               wr_n_r  <= 1'b1;
            end
            HOLD_A: begin
               if (hold_cnt_r == HOLD_LAST) begin
                  state_r    <= POLL_A;
               end else begin
                  hold_cnt_r <= hold_cnt_r + 4'd1;
               end
            end
            POLL_A: begin
               if (poll_done_s) begin
                  state_r <= WR_D;
                  cs_n_r  <= 1'b0;
                  wr_n_r  <= 1'b0;
                  addr_r  <= {work_r[8], 1'b1};
                  din_r   <= work_r[7:0];
                  if (busy_s) timeout_err_r <= 1'b1;
               end else begin
                  poll_cnt_r <= poll_cnt_r + 8'd1;
               end
            end
            WR_D: begin
               state_r <= HOLD_D;
               cs_n_r  <= 1'b1;
               wr_n_r  <= 1'b1;
            end
            HOLD_D: begin
               if (hold_cnt_r == HOLD_LAST) begin
                  state_r    <= POLL_D;
               end else begin
                  hold_cnt_r <= hold_cnt_r + 4'd1;
               end
            end
            POLL_D: begin
               if (poll_done_s) begin
                  if (busy_s) timeout_err_r <= 1'b1;
                  // Chain straight into the next address strobe when work is queued.
                  if (pop_s) begin
                     state_r <= WR_A;
                     cs_n_r  <= 1'b0;
                     wr_n_r  <= 1'b0;
                     addr_r  <= {head_s[16], 1'b0};
                     din_r   <= head_s[15:8];
                  end else begin
                     state_r <= IDLE;
                     idle_r  <= (cnt_nxt_s == CNT_ZERO);
                  end
               end else begin
                  poll_cnt_r <= poll_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               cs_n_r  <= 1'b1;
               wr_n_r  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.a_ack       = a_ack_r;
   assign bus.b_ack       = b_ack_r;
   assign bus.cs_n        = cs_n_r;
   assign bus.wr_n        = wr_n_r;
   assign bus.addr        = addr_r;
   assign bus.din         = din_r;
   assign bus.pending     = cnt_r;
   assign bus.idle        = idle_r;
   assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_jt12_wrsched.sv
// Directed bench for jt12_wrsched: one default instance and one with a short poll timeout.
// clk_en pulses every other clock so idle clocks between enables are exercised too.
module tb_jt12_wrsched;
   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic clk_en = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;
   int n_st     = 0;
   int consec   = 0;
   logic prev_low = 1'b0;
   logic [1:0] st_addr [64];
   logic [7:0] st_din  [64];
   int         st_edge [64];
   int t_st = 0;
   int t_st_edge [8];

   jt12_wrsched_if #(.DEPTH_LOG2(2)) m_if ();
   jt12_wrsched_if #(.DEPTH_LOG2(2)) t_if ();

   jt12_wrsched #(.DEPTH_LOG2(2), .HOLD(4), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(m_if)
   );

   jt12_wrsched #(.DEPTH_LOG2(2), .HOLD(4), .TIMEOUT(8)) dut_to (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(t_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      clk_en = 1'b0;
      m_if.a_req = 1'b0; m_if.a_part = 1'b0; m_if.a_reg = 8'h00; m_if.a_val = 8'h00;
      m_if.b_req = 1'b0; m_if.b_part = 1'b0; m_if.b_reg = 8'h00; m_if.b_val = 8'h00;
      m_if.chip_dout = 8'h00;
      t_if.a_req = 1'b0; t_if.a_part = 1'b0; t_if.a_reg = 8'h00; t_if.a_val = 8'h00;
      t_if.b_req = 1'b0; t_if.b_part = 1'b0; t_if.b_reg = 8'h00; t_if.b_val = 8'h00;
      t_if.chip_dout = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      edge_n = 0; n_st = 0; t_st = 0; prev_low = 1'b0;
   endtask

   // One clk_en edge followed by one disabled clock; sample at the falling edge.
   task automatic ce_step();
      clk_en = 1'b1;
      @(posedge clk);
      #1 clk_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      edge_n++;
      if (m_if.cs_n != m_if.wr_n) consec++;
      if (m_if.cs_n == 1'b0) begin
         if (prev_low) consec++;
         if (n_st < 64) begin
            st_addr[n_st] = m_if.addr;
            st_din[n_st]  = m_if.din;
            st_edge[n_st] = edge_n;
         end
         n_st++;
      end
      prev_low = (m_if.cs_n == 1'b0);
      if (t_if.cs_n == 1'b0) begin
         if (t_st < 8) t_st_edge[t_st] = edge_n;
         t_st++;
      end
   endtask

   task automatic wait_idle(input int max_edges, input string tag);
      int k = 0;
      while (m_if.idle !== 1'b1 && k < max_edges) begin
         ce_step();
         k++;
      end
      check(tag, m_if.idle, 1'b1);
   endtask

   initial begin
      int ia;
      int ib;
      int k;
      int err_edge;
      int max_pend;
      int acks_full;
      int pend_before;

      // Reset state
      do_reset();
      check("rst_cs_n", m_if.cs_n, 1'b1);
      check("rst_wr_n", m_if.wr_n, 1'b1);
      check("rst_addr", m_if.addr, 2'd0);
      check("rst_din", m_if.din, 8'h00);
      check("rst_acks", {m_if.a_ack, m_if.b_ack}, 2'b00);
      check("rst_pending", m_if.pending, 3'd0);
      check("rst_idle", m_if.idle, 1'b1);
      check("rst_terr", m_if.timeout_err, 1'b0);

      // Single write
      m_if.a_req = 1'b1; m_if.a_part = 1'b0; m_if.a_reg = 8'h28; m_if.a_val = 8'hF0;
      ce_step();
      check("t1_ack_hi", m_if.a_ack, 1'b1);
      check("t1_b_ack", m_if.b_ack, 1'b0);
      check("t1_pend1", m_if.pending, 3'd1);
      check("t1_idle_lo", m_if.idle, 1'b0);
      m_if.a_req = 1'b0;
      ce_step();
      check("t1_ack_lo", m_if.a_ack, 1'b0);
      check("t1_cs_lo", m_if.cs_n, 1'b0);
      check("t1_wr_lo", m_if.wr_n, 1'b0);
      check("t1_addr_a", m_if.addr, 2'd0);
      check("t1_din_a", m_if.din, 8'h28);
      check("t1_pend0", m_if.pending, 3'd0);
      ce_step();
      check("t1_cs_hold", m_if.cs_n, 1'b1);
      check("t1_din_hold", m_if.din, 8'h28);
      repeat (10) ce_step();
      check("t1_busy_before_end", m_if.idle, 1'b0);
      ce_step();
      check("t1_idle_end", m_if.idle, 1'b1);
      check("t1_nstrobes", n_st, 2);
      check("t1_gap", st_edge[1] - st_edge[0], 6);
      check("t1_addr_d", st_addr[1], 2'd1);
      check("t1_din_d", st_din[1], 8'hF0);

      // Busy stall for 20 enables after the address strobe
      do_reset();
      m_if.b_req = 1'b1; m_if.b_part = 1'b0; m_if.b_reg = 8'hB4; m_if.b_val = 8'hC0;
      ce_step();
      check("t2_b_ack", m_if.b_ack, 1'b1);
      m_if.b_req = 1'b0;
      ce_step();
      check("t2_din_a", m_if.din, 8'hB4);
      m_if.chip_dout = 8'h80;
      repeat (20) ce_step();
      check("t2_no_strobe_busy", n_st, 1);
      m_if.chip_dout = 8'h00;
      ce_step();
      check("t2_cs_d", m_if.cs_n, 1'b0);
      check("t2_addr_d", m_if.addr, 2'd1);
      check("t2_din_d", m_if.din, 8'hC0);
      check("t2_gap", st_edge[1] - st_edge[0], 21);
      wait_idle(20, "t2_idle");
      check("t2_terr", m_if.timeout_err, 1'b0);

      // Contention between A and B
      do_reset();
      ia = 0; ib = 0;
      m_if.a_req = 1'b1; m_if.a_reg = 8'h30; m_if.a_val = 8'h70;
      m_if.b_req = 1'b1; m_if.b_reg = 8'h40; m_if.b_val = 8'h80;
      for (int i = 0; i < 4; i++) begin
         ce_step();
         check("t3_a_ack", m_if.a_ack, (i % 2 == 0) ? 1 : 0);
         check("t3_b_ack", m_if.b_ack, (i % 2 == 1) ? 1 : 0);
         if (m_if.a_ack) begin
            ia++; m_if.a_reg = 8'h30 + 8'(ia); m_if.a_val = 8'h70 + 8'(ia);
         end
         if (m_if.b_ack) begin
            ib++; m_if.b_reg = 8'h40 + 8'(ib); m_if.b_val = 8'h80 + 8'(ib);
         end
      end
      m_if.a_req = 1'b0; m_if.b_req = 1'b0;
      wait_idle(100, "t3_idle");
      check("t3_nstrobes", n_st, 8);
      for (int i = 0; i < 4; i++) begin
         check("t3_order_reg", st_din[2*i], (i % 2 == 0) ? 32'h30 + i/2 : 32'h40 + i/2);
         check("t3_order_val", st_din[2*i+1], (i % 2 == 0) ? 32'h70 + i/2 : 32'h80 + i/2);
      end

      // Full FIFO with busy held, then drain
      do_reset();
      ia = 0; max_pend = 0; acks_full = 0;
      m_if.chip_dout = 8'h80;
      m_if.a_req = 1'b1; m_if.a_part = 1'b1; m_if.a_reg = 8'h50; m_if.a_val = 8'h60;
      for (int i = 0; i < 20; i++) begin
         pend_before = int'(m_if.pending);
         ce_step();
         if (m_if.a_ack) begin
            if (pend_before == 4) acks_full++;
            ia++;
            if (ia < 6) begin
               m_if.a_reg = 8'h50 + 8'(ia); m_if.a_val = 8'h60 + 8'(ia);
            end else begin
               m_if.a_req = 1'b0;
            end
         end
         if (int'(m_if.pending) > max_pend) max_pend = int'(m_if.pending);
      end
      check("t4_pend_sat", m_if.pending, 3'd4);
      check("t4_max_pend", max_pend, 4);
      check("t4_acks_full", acks_full, 0);
      check("t4_accepted", ia, 5);
      check("t4_one_strobe", n_st, 1);
      m_if.chip_dout = 8'h00;
      k = 0;
      while ((ia < 6 || m_if.idle !== 1'b1) && k < 150) begin
         ce_step();
         if (m_if.a_ack) begin
            ia++;
            if (ia < 6) begin
               m_if.a_reg = 8'h50 + 8'(ia); m_if.a_val = 8'h60 + 8'(ia);
            end else begin
               m_if.a_req = 1'b0;
            end
         end
         k++;
      end
      check("t4_drained", m_if.idle, 1'b1);
      check("t4_all_accepted", ia, 6);
      check("t4_nstrobes", n_st, 12);
      for (int i = 0; i < 6; i++) begin
         check("t4_addr_a", st_addr[2*i], 2'd2);
         check("t4_reg", st_din[2*i], 32'h50 + i);
         check("t4_addr_d", st_addr[2*i+1], 2'd3);
         check("t4_val", st_din[2*i+1], 32'h60 + i);
      end

      // Timeout with busy stuck high
      do_reset();
      err_edge = 0;
      t_if.chip_dout = 8'h80;
      t_if.a_req = 1'b1; t_if.a_part = 1'b0; t_if.a_reg = 8'h22; t_if.a_val = 8'h33;
      for (int i = 0; i < 30; i++) begin
         ce_step();
         if (t_if.a_ack) t_if.a_req = 1'b0;
         if (t_if.timeout_err && err_edge == 0) err_edge = edge_n;
      end
      check("t5_err_edge", err_edge, 15);
      check("t5_nstrobes", t_st, 2);
      check("t5_strobe_a", t_st_edge[0], 2);
      check("t5_strobe_d", t_st_edge[1], 15);
      check("t5_err_sticky", t_if.timeout_err, 1'b1);
      check("t5_idle", t_if.idle, 1'b1);

      // Asynchronous reset during the data strobe
      ia = 0;
      t_if.a_req = 1'b1; t_if.a_reg = 8'h10; t_if.a_val = 8'h90;
      k = 0;
      while (!(t_if.cs_n == 1'b0 && t_if.addr[0] == 1'b1) && k < 60) begin
         ce_step();
         if (t_if.a_ack) begin
            ia++;
            if (ia < 3) begin
               t_if.a_reg = 8'h10 + 8'(ia); t_if.a_val = 8'h90 + 8'(ia);
            end else begin
               t_if.a_req = 1'b0;
            end
         end
         k++;
      end
      check("t6_in_wr_d", t_if.cs_n, 1'b0);
      check("t6_pend_pre", t_if.pending, 3'd2);
      check("t6_err_pre", t_if.timeout_err, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_cs_n", t_if.cs_n, 1'b1);
      check("t6_wr_n", t_if.wr_n, 1'b1);
      check("t6_pending", t_if.pending, 3'd0);
      check("t6_idle", t_if.idle, 1'b1);
      check("t6_terr", t_if.timeout_err, 1'b0);
      @(negedge clk);
      t_if.a_req = 1'b0;
      rst_n = 1'b1;

      check("no_back_to_back", consec, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
